completion_bus: RTL and testbench
=================================

COMPLETION_BUS -- requirements
Module: completion_bus

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving per-source result FIFO depth (power of two, 2..16).
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have port flush  input  1  discard every buffered and pending result (branch redirect / exception).
REQ-005 The block SHALL have ports alu_done, mul_done, div_done, ls_done  input  1 each  source result strobe.
REQ-006 The block SHALL have ports alu_value, mul_value, div_value, ls_value  input  32 each  result data.
REQ-007 The block SHALL have ports alu_inst_num, mul_inst_num, div_inst_num, ls_inst_num  input  32 each  instruction tag.
REQ-008 The block SHALL have ports alu_exc, mul_exc, div_exc, ls_exc  input  2 each  exception cause, 00 = none.
REQ-009 The block SHALL have ports alu_ready, mul_ready, div_ready, ls_ready  output  1 each  FIFO can accept this cycle.
REQ-010 The block SHALL have port cdb_valid  output  1  broadcast result valid this cycle.
REQ-011 The block SHALL have ports cdb_value  output  32, cdb_inst_num  output  32, cdb_exc  output  2  broadcast payload.
REQ-012 The block SHALL have port cdb_src  output  2  granted source: 0 ALU, 1 MUL, 2 DIV, 3 LS.

Function
REQ-013 Per source: push occurs at a posedge when done=1 and ready=1; {value, inst_num, exc} is written to that source's FIFO tail.
REQ-014 ready SHALL equal (count < DEPTH), a registered-state function; done while ready=0 is dropped, with no state change.
REQ-015 Arbitration: each cycle, among sources with count>0, grant one by round-robin starting at (last_grant+1) mod 4, wrapping 3->0.
REQ-016 Grant pops the FIFO head and registers its payload onto cdb_* with cdb_valid=1 at the same edge; last_grant updates to the granted source.
REQ-017 No source non-empty: cdb_valid=0, cdb_value/cdb_inst_num/cdb_exc/cdb_src driven 0, last_grant unchanged.
REQ-018 Latency: a push accepted at edge k is eligible for grant in the cycle after edge k; earliest cdb_valid is after edge k+1; no input-to-output bypass.
REQ-019 A single source SHALL preserve FIFO order; ordering across sources is arbitration order only.
REQ-020 Simultaneous push and pop on the same FIFO SHALL be legal (count unchanged); at count==DEPTH, ready=0 so no push.
REQ-021 FIFO pointers SHALL be log2(DEPTH) bits, wrapping modulo DEPTH; count SHALL be log2(DEPTH)+1 bits.
REQ-022 flush=1 at an edge: all counts and pointers <=0, cdb_valid<=0 and cdb_* payload <=0, same-edge pushes discarded, no grant; last_grant unchanged.
REQ-023 cdb_valid SHALL be a single-cycle pulse per result; no result is broadcast twice.
REQ-024 A grant in every cycle with a non-empty source; no starvation: a non-empty source is granted within 4 cycles.

Reset
REQ-025 rst=1 SHALL immediately (without clock) clear all FIFO counts/pointers, set last_grant=3, cdb_valid=0, cdb_value=0, cdb_inst_num=0, cdb_exc=0, cdb_src=0, all ready=1.
REQ-026 Reset asserted mid-operation SHALL lose all buffered results; first accepted push after deassertion behaves per REQ-018.

Verification
REQ-027 After reset, ALU pushes value=0x11, inst_num=0x100 at edge 1 -> cdb_valid=1, cdb_value=0x11, cdb_inst_num=0x100, cdb_src=0 after edge 2 only.
REQ-028 All four sources push at the same edge (tags 0xA0..0xA3) -> next four cycles broadcast src 0,1,2,3 in order, then cdb_valid=0.
REQ-029 MUL pushes 5 results on consecutive edges with DEPTH=4 and no other traffic -> mul_ready=0 only when count=4; all accepted tags appear in push order; no tag is duplicated.
REQ-030 DIV pushes exc=01, tag 0x40 -> cdb_exc=01, cdb_src=2, cdb_inst_num=0x40 for exactly one cycle.
REQ-031 Three entries buffered in each of ALU and LS, flush=1 for one edge concurrent with a DIV push -> cdb_valid=0 for the next two cycles, all ready=1, DIV result never broadcast.
REQ-032 rst pulsed between clock edges while FIFOs hold data -> outputs zero immediately; subsequent traffic per REQ-027.

Source files
------------

// File: rtl/completion_bus_if.sv
// Execution-unit result strobes into the completion bus, plus the broadcast
// (CDB) side and flush. The arbiter is the slave; the producers/consumer side is the master.
interface completion_bus_if;
    logic        flush;

    logic        alu_done,     mul_done,     div_done,     ls_done;
    logic [31:0] alu_value,    mul_value,    div_value,    ls_value;
    logic [31:0] alu_inst_num, mul_inst_num, div_inst_num, ls_inst_num;
    logic [1:0]  alu_exc,      mul_exc,      div_exc,      ls_exc;
    logic        alu_ready,    mul_ready,    div_ready,    ls_ready;

    logic        cdb_valid;
    logic [31:0] cdb_value;
    logic [31:0] cdb_inst_num;
    logic [1:0]  cdb_exc;
    logic [1:0]  cdb_src;

    modport slave (
        input  flush,
        input  alu_done, mul_done, div_done, ls_done,
        input  alu_value, mul_value, div_value, ls_value,
        input  alu_inst_num, mul_inst_num, div_inst_num, ls_inst_num,
        input  alu_exc, mul_exc, div_exc, ls_exc,
        output alu_ready, mul_ready, div_ready, ls_ready,
        output cdb_valid, cdb_value, cdb_inst_num, cdb_exc, cdb_src
    );

    modport master (
        output flush,
        output alu_done, mul_done, div_done, ls_done,
        output alu_value, mul_value, div_value, ls_value,
        output alu_inst_num, mul_inst_num, div_inst_num, ls_inst_num,
        output alu_exc, mul_exc, div_exc, ls_exc,
        input  alu_ready, mul_ready, div_ready, ls_ready,
        input  cdb_valid, cdb_value, cdb_inst_num, cdb_exc, cdb_src
    );
endinterface

// File: rtl/completion_bus.sv
// Common data bus: four per-source result FIFOs drained one result per cycle
// by a round-robin arbiter onto a registered broadcast.
module completion_bus #(
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    completion_bus_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [31:0] value;
        logic [31:0] inst_num;
        logic [1:0]  exc;
    } entry_t;

    logic [3:0]    done, ready, push, pop;
    entry_t        in_entry [4];
    entry_t        mem_q    [4][DEPTH];
    logic [AW-1:0] wr_ptr_q [4], wr_ptr_d [4];
    logic [AW-1:0] rd_ptr_q [4], rd_ptr_d [4];
    logic [CW-1:0] count_q  [4], count_d  [4];
    logic [1:0]    last_grant_q, last_grant_d;
    logic          grant_valid;
    logic [1:0]    grant_src;
    logic          cdb_valid_q, cdb_valid_d;
    entry_t        cdb_q, cdb_d;
    logic [1:0]    cdb_src_q, cdb_src_d;

    assign done        = {bus.ls_done, bus.div_done, bus.mul_done, bus.alu_done};
    assign in_entry[0] = {bus.alu_value, bus.alu_inst_num, bus.alu_exc};
    assign in_entry[1] = {bus.mul_value, bus.mul_inst_num, bus.mul_exc};
    assign in_entry[2] = {bus.div_value, bus.div_inst_num, bus.div_exc};
    assign in_entry[3] = {bus.ls_value,  bus.ls_inst_num,  bus.ls_exc};

    // Round-robin: first non-empty source after the last winner; offset 4 wraps back to it.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        grant_valid = 1'b0;
        grant_src   = 2'd0;
        for (int off = 1; off <= 4; off++) begin
            if (!grant_valid && count_q[last_grant_q + 2'(off)] != '0) begin
                grant_valid = 1'b1;
                grant_src   = last_grant_q + 2'(off);
            end
        end
    end

    always_comb begin
        for (int s = 0; s < 4; s++) begin
            ready[s] = count_q[s] < CW'(DEPTH);
            push[s]  = done[s] & ready[s] & ~bus.flush;
            pop[s]   = grant_valid && (grant_src == 2'(s)) && !bus.flush;
        end
    end

    always_comb begin
        for (int s = 0; s < 4; s++) begin
            wr_ptr_d[s] = wr_ptr_q[s];
            rd_ptr_d[s] = rd_ptr_q[s];
            count_d[s]  = count_q[s];
            if (bus.flush) begin
                wr_ptr_d[s] = '0;
                rd_ptr_d[s] = '0;
                count_d[s]  = '0;
            end else begin
                if (push[s]) wr_ptr_d[s] = wr_ptr_q[s] + AW'(1);
                if (pop[s])  rd_ptr_d[s] = rd_ptr_q[s] + AW'(1);
                case ({push[s], pop[s]})
                    2'b10:   count_d[s] = count_q[s] + CW'(1);
                    2'b01:   count_d[s] = count_q[s] - CW'(1);
                    default: count_d[s] = count_q[s];
                endcase
            end
        end

        cdb_valid_d  = 1'b0;
        cdb_d        = '0;
        cdb_src_d    = 2'd0;
        last_grant_d = last_grant_q;
        if (!bus.flush && grant_valid) begin
            cdb_valid_d  = 1'b1;
            cdb_d        = mem_q[grant_src][rd_ptr_q[grant_src]];
            cdb_src_d    = grant_src;
            last_grant_d = grant_src;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < 4; s++) begin
                wr_ptr_q[s] <= '0;
                rd_ptr_q[s] <= '0;
                count_q[s]  <= '0;
            end
            last_grant_q <= 2'd3;
            cdb_valid_q  <= 1'b0;
            cdb_q        <= '0;
            cdb_src_q    <= 2'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            for (int s = 0; s < 4; s++) begin
                wr_ptr_q[s] <= wr_ptr_d[s];
                rd_ptr_q[s] <= rd_ptr_d[s];
                count_q[s]  <= count_d[s];
            end
            last_grant_q <= last_grant_d;
            cdb_valid_q  <= cdb_valid_d;
            cdb_q        <= cdb_d;
            cdb_src_q    <= cdb_src_d;
        end
    end

    // NOTE: storage is not reset; counts gate every read, so stale entries are never observed.
    always_ff @(posedge clk) begin
        for (int s = 0; s < 4; s++) begin
            if (push[s]) mem_q[s][wr_ptr_q[s]] <= in_entry[s];
        end
    end

    assign bus.alu_ready    = ready[0];
    assign bus.mul_ready    = ready[1];
    assign bus.div_ready    = ready[2];
    assign bus.ls_ready     = ready[3];
    assign bus.cdb_valid    = cdb_valid_q;
    assign bus.cdb_value    = cdb_q.value;
    assign bus.cdb_inst_num = cdb_q.inst_num;
    assign bus.cdb_exc      = cdb_q.exc;
    assign bus.cdb_src      = cdb_src_q;
endmodule

// File: tb/tb_completion_bus.sv
// Directed bench for completion_bus: queue-based reference model compared every
// cycle, plus hand-computed literal expectations for the key scenarios.
module tb_completion_bus;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] value;
        logic [31:0] tag;
        logic [1:0]  exc;
    } entry_t;

    logic        clk;
    logic        rst;
    logic        flush_r;
    logic        done_r [4];
    logic [31:0] val_r  [4];
    logic [31:0] tag_r  [4];
    logic [1:0]  exc_r  [4];
    logic [3:0]  dut_ready;

    int checks = 0;
    int errors = 0;

    completion_bus_if bus ();

    completion_bus #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.flush        = flush_r;
    assign bus.alu_done     = done_r[0];
    assign bus.mul_done     = done_r[1];
    assign bus.div_done     = done_r[2];
    assign bus.ls_done      = done_r[3];
    assign bus.alu_value    = val_r[0];
    assign bus.mul_value    = val_r[1];
    assign bus.div_value    = val_r[2];
    assign bus.ls_value     = val_r[3];
    assign bus.alu_inst_num = tag_r[0];
    assign bus.mul_inst_num = tag_r[1];
    assign bus.div_inst_num = tag_r[2];
    assign bus.ls_inst_num  = tag_r[3];
    assign bus.alu_exc      = exc_r[0];
    assign bus.mul_exc      = exc_r[1];
    assign bus.div_exc      = exc_r[2];
    assign bus.ls_exc       = exc_r[3];
    assign dut_ready        = {bus.ls_ready, bus.div_ready, bus.mul_ready, bus.alu_ready};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one queue per source, one grant per cycle, round-robin pointer.
    entry_t      mq [4][$];
    int          lg;
    int          idx;
    bit          acc [4];
    entry_t      me;
    logic        exp_valid;
    logic [31:0] exp_value, exp_tag;
    logic [1:0]  exp_exc, exp_src;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < 4; s++) mq[s].delete();
            lg        = 3;
            exp_valid = 1'b0;
            exp_value = '0;
            exp_tag   = '0;
            exp_exc   = '0;
            exp_src   = '0;
        end else begin
            for (int s = 0; s < 4; s++) acc[s] = done_r[s] && (mq[s].size() < DEPTH);
            exp_valid = 1'b0;
            exp_value = '0;
            exp_tag   = '0;
            exp_exc   = '0;
            exp_src   = '0;
            if (flush_r) begin
                for (int s = 0; s < 4; s++) mq[s].delete();
            end else begin
                for (int k = 1; k <= 4; k++) begin
                    idx = (lg + k) % 4;
                    if (!exp_valid && mq[idx].size() > 0) begin
                        me        = mq[idx].pop_front();
                        exp_valid = 1'b1;
                        exp_value = me.value;
                        exp_tag   = me.tag;
                        exp_exc   = me.exc;
                        exp_src   = 2'(idx);
                        lg        = idx;
                    end
                end
                for (int s = 0; s < 4; s++)
                    if (acc[s]) mq[s].push_back('{val_r[s], tag_r[s], exc_r[s]});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("cmp_valid", 32'(bus.cdb_valid), 32'(exp_valid));
            check("cmp_value", bus.cdb_value, exp_value);
            check("cmp_inst_num", bus.cdb_inst_num, exp_tag);
            check("cmp_exc", 32'(bus.cdb_exc), 32'(exp_exc));
            check("cmp_src", 32'(bus.cdb_src), 32'(exp_src));
            for (int s = 0; s < 4; s++)
                check($sformatf("cmp_ready%0d", s), 32'(dut_ready[s]), 32'(mq[s].size() < DEPTH));
        end
    end

    task automatic clear_inputs();
        flush_r = 1'b0;
        for (int s = 0; s < 4; s++) begin
            done_r[s] = 1'b0;
            val_r[s]  = '0;
            tag_r[s]  = '0;
            exc_r[s]  = '0;
        end
    endtask

    task automatic set_src(input int s, input logic [31:0] v, input logic [31:0] t, input logic [1:0] e);
        done_r[s] = 1'b1;
        val_r[s]  = v;
        tag_r[s]  = t;
        exc_r[s]  = e;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"}, 32'(bus.cdb_valid), 32'd0);
        check({tag, "_value"}, bus.cdb_value, 32'd0);
        check({tag, "_inst"}, bus.cdb_inst_num, 32'd0);
        check({tag, "_exc"}, 32'(bus.cdb_exc), 32'd0);
        check({tag, "_src"}, 32'(bus.cdb_src), 32'd0);
        check({tag, "_ready"}, 32'(dut_ready), 32'hF);
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        #2;
        check_zero_outputs("reset");
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        do_reset();

        // Single ALU result: visible only after the second edge.
        set_src(0, 32'h11, 32'h100, 2'b00);
        tick();
        check("alu_no_bypass", 32'(bus.cdb_valid), 32'd0);
        clear_inputs();
        tick();
        check("alu_valid", 32'(bus.cdb_valid), 32'd1);
        check("alu_value", bus.cdb_value, 32'h11);
        check("alu_inst", bus.cdb_inst_num, 32'h100);
        check("alu_src", 32'(bus.cdb_src), 32'd0);
        tick();
        check("alu_pulse", 32'(bus.cdb_valid), 32'd0);

        // All four push together: broadcast in order 0..3.
        do_reset();
        for (int s = 0; s < 4; s++) set_src(s, 32'hB0 + 32'(s), 32'hA0 + 32'(s), 2'b00);
        tick();
        clear_inputs();
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("rr_src%0d", i), 32'(bus.cdb_src), 32'(i));
            check($sformatf("rr_inst%0d", i), bus.cdb_inst_num, 32'hA0 + 32'(i));
        end
        tick();
        check("rr_idle", 32'(bus.cdb_valid), 32'd0);

        // MUL alone: drains one per cycle, so it never fills.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_src(1, 32'h500 + 32'(i), 32'h50 + 32'(i), 2'b00);
            tick();
            check($sformatf("mul_ready%0d", i), 32'(bus.mul_ready), 32'd1);
            if (i > 0) check($sformatf("mul_order%0d", i), bus.cdb_inst_num, 32'h50 + 32'(i - 1));
        end
        clear_inputs();
        tick();
        check("mul_last", bus.cdb_inst_num, 32'h54);
        tick();
        check("mul_idle", 32'(bus.cdb_valid), 32'd0);

        // All four push every cycle: counts outrun the single grant and fill up.
        do_reset();
        for (int c = 0; c < 6; c++) begin
            for (int s = 0; s < 4; s++) set_src(s, 32'(c), 32'h1000 * 32'(s + 1) + 32'(c), 2'b00);
            tick();
            if (c == 3) begin
                check("fill_ls_full", 32'(bus.ls_ready), 32'd0);
                check("fill_alu_ok", 32'(bus.alu_ready), 32'd1);
            end
            if (c == 4) begin
                check("fill_alu_full", 32'(bus.alu_ready), 32'd0);
                check("fill_ls_ok", 32'(bus.ls_ready), 32'd1);
            end
        end
        clear_inputs();
        repeat (20) tick();
        check("fill_drained", 32'(bus.cdb_valid), 32'd0);

        // DIV exception result.
        do_reset();
        set_src(2, 32'hDEAD, 32'h40, 2'b01);
        tick();
        clear_inputs();
        tick();
        check("div_valid", 32'(bus.cdb_valid), 32'd1);
        check("div_exc", 32'(bus.cdb_exc), 32'd1);
        check("div_src", 32'(bus.cdb_src), 32'd2);
        check("div_inst", bus.cdb_inst_num, 32'h40);
        tick();
        check("div_pulse", 32'(bus.cdb_valid), 32'd0);

        // Build three entries in ALU and LS, then flush alongside a DIV push.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_src(0, 32'(i), 32'h300 + 32'(i), 2'b00);
            set_src(3, 32'(i), 32'h330 + 32'(i), 2'b00);
            tick();
        end
        clear_inputs();
        flush_r = 1'b1;
        set_src(2, 32'h77, 32'h77, 2'b00);
        tick();
        check_zero_outputs("flush0");
        clear_inputs();
        tick();
        check("flush1_valid", 32'(bus.cdb_valid), 32'd0);
        tick();
        check("flush2_valid", 32'(bus.cdb_valid), 32'd0);

        // Reset pulse between edges with data buffered, then fresh traffic.
        do_reset();
        set_src(0, 32'hAA, 32'h200, 2'b00);
        set_src(1, 32'hBB, 32'h201, 2'b00);
        tick();
        tick();
        clear_inputs();
        check("pre_rst_valid", 32'(bus.cdb_valid), 32'd1);
        #1 rst = 1'b1;
        #1 check_zero_outputs("mid_rst");
        #1 rst = 1'b0;
        set_src(0, 32'h11, 32'h100, 2'b00);
        tick();
        check("post_rst_no_bypass", 32'(bus.cdb_valid), 32'd0);
        clear_inputs();
        tick();
        check("post_rst_valid", 32'(bus.cdb_valid), 32'd1);
        check("post_rst_value", bus.cdb_value, 32'h11);
        check("post_rst_inst", bus.cdb_inst_num, 32'h100);
        tick();
        check("post_rst_idle", 32'(bus.cdb_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
